// File: rtl/meas_pkg.sv
// Shared types and defaults for the measurement sampler: FSM state encoding,
// default widths and the threshold slice taken from the random word.
package meas_pkg;

   localparam int DEF_INDEX_WIDTH = 4;
   localparam int DEF_PROB_WIDTH  = 16;
   localparam int DEF_RAND_WIDTH  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } meas_state_t;

   // Top prob_w bits of a rand_w-bit word, right-aligned; caller truncates.
   function automatic logic [63:0] thr_slice(input logic [63:0] rnd,
                                             input int rand_w,
                                             input int prob_w);
      return rnd >> (rand_w - prob_w);
   endfunction

endpackage

// File: rtl/measurement_accumulator.sv
// Cumulative-probability scan: holds threshold and running sum, flags the first index whose sum exceeds it.
// Latency: one cycle from read data to registered hit/exhausted; no backpressure, data consumed when dat_vld.
module measurement_accumulator
   import meas_pkg::*;
#(
   parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
   parameter int PROB_WIDTH  = DEF_PROB_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic [PROB_WIDTH-1:0]  thr_in,
   input  logic                   dat_vld,
   input  logic [INDEX_WIDTH-1:0] dat_idx,
   input  logic [PROB_WIDTH-1:0]  dat,
   output logic                   hit,
   output logic                   exhausted,
   output logic [INDEX_WIDTH-1:0] index_of_hit
`ifdef MEAS_PROB_OUT_EN
   ,
   output logic [PROB_WIDTH-1:0]  prob_of_hit
`endif
);

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

   logic [PROB_WIDTH:0]   acc;
   logic [PROB_WIDTH:0]   acc_next;
   logic [PROB_WIDTH-1:0] thr;
   logic                  over_thr;

   // acc stays <= thr until the hit, so one extra bit holds the sum without wrap.
   assign acc_next = acc + {1'b0, dat};
   assign over_thr = acc_next > {1'b0, thr};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         thr          <= '0;
         hit          <= 1'b0;
         exhausted    <= 1'b0;
         index_of_hit <= '0;
`ifdef MEAS_PROB_OUT_EN
         prob_of_hit  <= '0;
`endif
      end else if (clear) begin
         acc          <= '0;
         thr          <= thr_in;
         hit          <= 1'b0;
         exhausted    <= 1'b0;
         index_of_hit <= '0;
      end else if (dat_vld && !hit && !exhausted) begin
         acc <= acc_next;
         if (over_thr) begin
            hit          <= 1'b1;
            index_of_hit <= dat_idx;
`ifdef MEAS_PROB_OUT_EN
            prob_of_hit  <= dat;
`endif
         end else if (dat_idx == LAST_IDX) begin
            exhausted    <= 1'b1;
            index_of_hit <= LAST_IDX;
`ifdef MEAS_PROB_OUT_EN
            prob_of_hit  <= dat;
`endif
         end
      end
   end

endmodule

// File: rtl/measurement_sampler.sv
// Simulated projective measurement: random threshold vs. cumulative probability scan; result index k valid 3+k cycles after start.
// Result held in DONE until result_ready; start ignored outside IDLE. MEAS_PROB_OUT_EN adds result_prob.
module measurement_sampler
   import meas_pkg::*;
#(
   parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
   parameter int PROB_WIDTH  = DEF_PROB_WIDTH,
   parameter int RAND_WIDTH  = DEF_RAND_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [RAND_WIDTH-1:0]  random_num,
   input  logic                   start,
   output logic                   busy,
   output logic                   prob_re,
   output logic [INDEX_WIDTH-1:0] prob_addr,
   input  logic [PROB_WIDTH-1:0]  prob_rdata,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [INDEX_WIDTH-1:0] result_index,
   output logic                   result_sat
`ifdef MEAS_PROB_OUT_EN
   ,
   output logic [PROB_WIDTH-1:0]  result_prob
`endif
);

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

   meas_state_t            state;
   logic                   rd_vld;
   logic [INDEX_WIDTH-1:0] rd_idx;
   logic                   acc_clear;
   logic [PROB_WIDTH-1:0]  thr_new;
   logic                   acc_hit;
   logic                   acc_exh;
   logic [INDEX_WIDTH-1:0] acc_idx;
`ifdef MEAS_PROB_OUT_EN
   logic [PROB_WIDTH-1:0]  acc_prob;
`endif

   assign acc_clear = (state == IDLE) && start;
   assign thr_new   = PROB_WIDTH'(thr_slice(64'(random_num), RAND_WIDTH, PROB_WIDTH));

   // Read data is only meaningful while scanning; late returns after a hit are dropped.
   measurement_accumulator #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .PROB_WIDTH  (PROB_WIDTH)
   ) u_acc (
      .clk          (clk),
      .rst          (rst),
      .clear        (acc_clear),
      .thr_in       (thr_new),
      .dat_vld      (rd_vld && (state == SCAN)),
      .dat_idx      (rd_idx),
      .dat          (prob_rdata),
      .hit          (acc_hit),
      .exhausted    (acc_exh),
      .index_of_hit (acc_idx)
`ifdef MEAS_PROB_OUT_EN
      ,
      .prob_of_hit  (acc_prob)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         prob_re      <= 1'b0;
         prob_addr    <= '0;
         result_valid <= 1'b0;
         result_index <= '0;
         result_sat   <= 1'b0;
         rd_vld       <= 1'b0;
         rd_idx       <= '0;
`ifdef MEAS_PROB_OUT_EN
         result_prob  <= '0;
`endif
      end else begin
         rd_vld <= prob_re;
         rd_idx <= prob_addr;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN;
                  busy      <= 1'b1;
                  prob_re   <= 1'b1;
                  prob_addr <= '0;
               end
            end
            SCAN: begin
               if (acc_hit || acc_exh) begin
                  state        <= DONE;
                  prob_re      <= 1'b0;
                  result_valid <= 1'b1;
                  result_index <= acc_idx;
                  result_sat   <= acc_exh;
`ifdef MEAS_PROB_OUT_EN
                  result_prob  <= acc_prob;
`endif
               end else if (prob_re) begin
                  if (prob_addr == LAST_IDX) begin
                     prob_re <= 1'b0;
                  end else begin
                     prob_addr <= prob_addr + 1'b1;
                  end
               end
            end
            DONE: begin
               if (result_ready) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  result_valid <= 1'b0;
                  result_sat   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_measurement_sampler.sv
// Directed bench for measurement_sampler: table of memory patterns/thresholds plus DONE-hold and mid-scan reset sequences.
module tb_measurement_sampler;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] random_num;
   logic        start;
   logic        busy;
   logic        prob_re;
   logic [3:0]  prob_addr;
   logic [15:0] prob_rdata;
   logic        result_valid;
   logic        result_ready;
   logic [3:0]  result_index;
   logic        result_sat;
`ifdef MEAS_PROB_OUT_EN
   logic [15:0] result_prob;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int t0;
   logic [15:0] mem [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Probability memory: one-cycle read, garbage when not enabled.
   always @(posedge clk) begin
      if (prob_re) prob_rdata <= mem[prob_addr];
      else         prob_rdata <= 16'hFFFF;
   end

   measurement_sampler dut (
      .clk          (clk),
      .rst          (rst),
      .random_num   (random_num),
      .start        (start),
      .busy         (busy),
      .prob_re      (prob_re),
      .prob_addr    (prob_addr),
      .prob_rdata   (prob_rdata),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_index (result_index),
      .result_sat   (result_sat)
`ifdef MEAS_PROB_OUT_EN
      ,
      .result_prob  (result_prob)
`endif
   );

   typedef struct {
      logic [15:0] base;
      int          ia;
      logic [15:0] va;
      int          ib;
      logic [15:0] vb;
      logic [15:0] thr;
      int          eidx;
      logic        esat;
      int          elat;
      logic [15:0] eprob;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load_mem(input vec_t v);
      for (int i = 0; i < 16; i++) mem[i] = v.base;
      mem[v.ia] = v.va;
      mem[v.ib] = v.vb;
   endtask

   // Called just after an edge with the DUT idle; returns just after the start edge.
   task automatic issue_start(input logic [15:0] thr);
      random_num = {thr, 16'h5A5A};
      start = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b0;
      random_num = ~random_num;
   endtask

   task automatic wait_valid(input string nm, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         random_num = $urandom;
         if (result_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL %s: result_valid never rose within 40 cycles", nm);
      end
   endtask

   task automatic run_vec(input int i);
      bit ok;
      vec_t v = vt[i];
      load_mem(v);
      issue_start(v.thr);
      chk($sformatf("v%0d first_addr", i), {31'd0, prob_re, 4'd0} | 32'(prob_addr), 32'h10);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
      wait_valid($sformatf("v%0d valid", i), ok);
      if (ok) begin
         chk($sformatf("v%0d latency", i), 32'(cyc - t0), 32'(v.elat));
         chk($sformatf("v%0d index", i), 32'(result_index), 32'(v.eidx));
         chk($sformatf("v%0d sat", i), 32'(result_sat), 32'(v.esat));
`ifdef MEAS_PROB_OUT_EN
         chk($sformatf("v%0d prob", i), 32'(result_prob), 32'(v.eprob));
`endif
         result_ready = 1'b1;
         @(posedge clk); #1;
         result_ready = 1'b0;
         chk($sformatf("v%0d ack_valid", i), 32'(result_valid), 32'd0);
         chk($sformatf("v%0d ack_busy", i), 32'(busy), 32'd0);
         chk($sformatf("v%0d ack_sat", i), 32'(result_sat), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      vt[0] = '{16'h1000, 0, 16'h1000, 0, 16'h1000, 16'h2A00,  2, 1'b0,  5, 16'h1000};
      vt[1] = '{16'h0000, 9, 16'hFFFF, 9, 16'hFFFF, 16'h0000,  9, 1'b0, 12, 16'hFFFF};
      vt[2] = '{16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h1234, 15, 1'b1, 18, 16'h0000};
      vt[3] = '{16'h1000, 0, 16'h1000, 0, 16'h1000, 16'h0FFF,  0, 1'b0,  3, 16'h1000};
      vt[4] = '{16'h1000, 0, 16'h1000, 0, 16'h1000, 16'h1000,  1, 1'b0,  4, 16'h1000};
      vt[5] = '{16'h1000, 0, 16'h1000, 0, 16'h1000, 16'hFFFF, 15, 1'b0, 18, 16'h1000};
      vt[6] = '{16'h0000, 0, 16'h8000, 1, 16'h8000, 16'h9000,  1, 1'b0,  4, 16'h8000};
      vt[7] = '{16'h0FFF, 0, 16'h0FFF, 0, 16'h0FFF, 16'hFFFF, 15, 1'b1, 18, 16'h0FFF};
      vt[8] = '{16'h0000, 3, 16'h0001, 3, 16'h0001, 16'h0000,  3, 1'b0,  6, 16'h0001};

      rst = 1'b1;
      start = 1'b0;
      result_ready = 1'b0;
      random_num = 32'hDEAD_BEEF;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset prob_re", 32'(prob_re), 32'd0);
      chk("reset result_valid", 32'(result_valid), 32'd0);
      chk("reset result_sat", 32'(result_sat), 32'd0);
      chk("reset prob_addr", 32'(prob_addr), 32'd0);
      chk("reset result_index", 32'(result_index), 32'd0);
`ifdef MEAS_PROB_OUT_EN
      chk("reset result_prob", 32'(result_prob), 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         run_vec(i);
         @(posedge clk); #1;
      end

      // Result held under backpressure; start pulses in DONE are ignored.
      load_mem(vt[0]);
      issue_start(16'h2A00);
      wait_valid("hold valid", ok);
      if (ok) begin
         for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            random_num = 32'h0000_0000;
            @(posedge clk); #1;
            chk($sformatf("hold%0d index", c), 32'(result_index), 32'd2);
            chk($sformatf("hold%0d valid", c), 32'(result_valid), 32'd1);
            chk($sformatf("hold%0d busy", c), 32'(busy), 32'd1);
            chk($sformatf("hold%0d prob_re", c), 32'(prob_re), 32'd0);
         end
         start = 1'b1;
         result_ready = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         result_ready = 1'b0;
         chk("hold ack valid", 32'(result_valid), 32'd0);
         chk("hold ack busy", 32'(busy), 32'd0);
         @(posedge clk); #1;
         chk("hold start ignored busy", 32'(busy), 32'd0);
         chk("hold start ignored prob_re", 32'(prob_re), 32'd0);
      end

      // Reset while address 5 is on the bus, then a clean restart.
      load_mem(vt[5]);
      issue_start(16'hFFFF);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (prob_addr == 4'd5) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("midrst reached addr5", 32'(ok), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst prob_re", 32'(prob_re), 32'd0);
      chk("midrst result_valid", 32'(result_valid), 32'd0);
      @(posedge clk); #1;
      chk("midrst idle valid", 32'(result_valid), 32'd0);
      run_vec(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
